// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_adder
// Description : Pipelined ripple-carry add/subtract unit. The WIDTH-bit
//               operation is split into STAGES carry-chained chunks, one per
//               clock, with a valid/ready handshake. Define
//               PIPELINED_ADDER_SAT_EN for signed saturation on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = WIDTH / STAGES;

  if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_eff;
  logic             carry0;

  // The whole pipe freezes only while a finished result waits on the consumer.
  assign in_ready = !(out_valid && !out_ready);
  assign advance  = in_ready;
  assign accept   = in_valid && in_ready;
  assign b_eff    = sub ? ~b : b;
  assign carry0   = sub ? 1'b1 : carry_in;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                   v_q;
    logic                   c_q;
    logic [(k+1)*CHUNK-1:0] s_q;
    logic                   v_in;
    logic                   c_in;
    logic [CHUNK-1:0]       a_in;
    logic [CHUNK-1:0]       b_in;
    logic [CHUNK:0]         part;
    logic [(k+1)*CHUNK-1:0] s_d;
    logic [(k+1)*CHUNK-1:0] s_fin;

    if (k == 0) begin : g_src
      assign v_in = accept;
      assign c_in = carry0;
      assign a_in = a[CHUNK-1:0];
      assign b_in = b_eff[CHUNK-1:0];
      assign s_d  = part[CHUNK-1:0];
    end else begin : g_src
      assign v_in = g_stage[k-1].v_q;
      assign c_in = g_stage[k-1].c_q;
      assign a_in = g_stage[k-1].g_skew.a_q[CHUNK-1:0];
      assign b_in = g_stage[k-1].g_skew.b_q[CHUNK-1:0];
      assign s_d  = {part[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign part = {1'b0, a_in} + {1'b0, b_in} + {{CHUNK{1'b0}}, c_in};

    // Operand chunks not yet consumed ride along with the beat.
    if (k < STAGES-1) begin : g_skew
      logic [(STAGES-1-k)*CHUNK-1:0] a_q;
      logic [(STAGES-1-k)*CHUNK-1:0] b_q;
      logic [(STAGES-1-k)*CHUNK-1:0] a_d;
      logic [(STAGES-1-k)*CHUNK-1:0] b_d;

      if (k == 0) begin : g_src
        assign a_d = a[WIDTH-1:CHUNK];
        assign b_d = b_eff[WIDTH-1:CHUNK];
      end else begin : g_src
        assign a_d = g_stage[k-1].g_skew.a_q[(STAGES-k)*CHUNK-1:CHUNK];
        assign b_d = g_stage[k-1].g_skew.b_q[(STAGES-k)*CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= a_d;
          b_q <= b_d;
        end
      end
    end

    if (k == STAGES-1) begin : g_last
      logic ovf_q;
      logic ovf_d;

      assign ovf_d = (a_in[CHUNK-1] == b_in[CHUNK-1]) && (part[CHUNK-1] != a_in[CHUNK-1]);
`ifdef PIPELINED_ADDER_SAT_EN
      assign s_fin = !ovf_d        ? s_d :
                     a_in[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                     {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign s_fin = s_d;
`endif

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_d;
        end
      end
    end else begin : g_mid
      assign s_fin = s_d;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (advance) begin
        v_q <= v_in;
        c_q <= part[CHUNK];
        s_q <= s_fin;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].s_q;
  assign carry_out = g_stage[STAGES-1].c_q;
  assign overflow  = g_stage[STAGES-1].g_last.ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_adder
// Description : Directed vector table, stall/reset sequences and a 16/4
//               streaming run against a whole-width reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int NRAND = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_ready, carry_in = 1'b0, sub = 1'b0;
  logic       out_valid, out_ready = 1'b1, carry_out, overflow;
  logic [7:0] a = '0, b = '0, sum;

  logic        rnd_in_valid = 1'b0, rnd_in_ready, rnd_ci = 1'b0, rnd_sub = 1'b0;
  logic        rnd_out_valid, rnd_out_ready = 1'b0, rnd_co, rnd_ov;
  logic [15:0] rnd_a = '0, rnd_b = '0, rnd_sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .carry_in(carry_in), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow)
  );

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut_wide (
    .clk(clk), .rst(rst), .in_valid(rnd_in_valid), .in_ready(rnd_in_ready),
    .a(rnd_a), .b(rnd_b), .carry_in(rnd_ci), .sub(rnd_sub),
    .out_valid(rnd_out_valid), .out_ready(rnd_out_ready),
    .sum(rnd_sum), .carry_out(rnd_co), .overflow(rnd_ov)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic       sb;
    logic [7:0] sum;
    logic       co;
    logic       ov;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at one time unit after a rising edge with the pipe empty of stalls.
  task automatic run_vec(input vec_t v, input int idx);
    chk($sformatf("v%0d_in_ready", idx), {31'd0, in_ready}, 32'd1);
    a = v.a; b = v.b; carry_in = v.ci; sub = v.sb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk($sformatf("v%0d_not_early", idx), {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk($sformatf("v%0d_valid", idx), {31'd0, out_valid}, 32'd1);
    chk($sformatf("v%0d_sum", idx), {24'd0, sum}, {24'd0, v.sum});
    chk($sformatf("v%0d_carry", idx), {31'd0, carry_out}, {31'd0, v.co});
    chk($sformatf("v%0d_ovf", idx), {31'd0, overflow}, {31'd0, v.ov});
  endtask

  // Whole-width reference: returns {overflow, carry_out, sum}.
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    logic [15:0] ye;
    logic [16:0] full;
    logic [15:0] r;
    logic        ov;
    ye   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, ye} + {16'd0, (s ? 1'b1 : ci)};
    r    = full[15:0];
    ov   = (x[15] == ye[15]) && (r[15] != x[15]);
    if (SAT && ov) r = x[15] ? 16'h8000 : 16'h7FFF;
    return {ov, full[16], r};
  endfunction

  initial begin
    logic [17:0] q[$];
    logic [17:0] exp;
    int sent, got, cyc;

    vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, (SAT ? 8'h7F : 8'h80), 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[2] = '{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b0, 1'b1, (SAT ? 8'h80 : 8'h7F), 1'b1, 1'b1};
    vecs[5] = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[6] = '{8'h10, 8'h10, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7] = '{8'h80, 8'h80, 1'b0, 1'b0, (SAT ? 8'h80 : 8'h00), 1'b1, 1'b1};
    vecs[8] = '{8'h3C, 8'h45, 1'b1, 1'b0, (SAT ? 8'h7F : 8'h82), 1'b0, 1'b1};
    vecs[9] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_carry", {31'd0, carry_out}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_wide_valid", {31'd0, rnd_out_valid}, 32'd0);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // Back-to-back stream with a three-cycle consumer stall.
    @(posedge clk); #1;
    a = 8'd1; b = 8'd1; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 8'd2; b = 8'd2;
    @(posedge clk); #1;
    chk("stream_first", {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h02});
    a = 8'd3; b = 8'd3; out_ready = 1'b0;
    #1;
    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold%0d", i), {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h02});
      chk($sformatf("stall_ready%0d", i), {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("stream_second", {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h04});
    a = 8'd4; b = 8'd4;
    @(posedge clk); #1;
    chk("stream_third", {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h06});
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("stream_fourth", {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h08});
    @(posedge clk); #1;
    chk("stream_drained", {31'd0, out_valid}, 32'd0);

    // Reset with beats in flight and a simultaneous accept attempt.
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    chk("pre_rst_result", {23'd0, out_valid, sum}, {23'd0, 1'b1, 8'h33});
    rst = 1'b1; a = 8'h55; b = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {24'd0, sum}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("no_stale%0d", i), {31'd0, out_valid}, 32'd0);
    end
    run_vec('{8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0}, 99);

    // Streaming run on the 16-bit, 4-stage instance.
    sent = 0; got = 0; cyc = 0;
    while (got < NRAND && cyc < 20000) begin
      @(posedge clk); #1;
      rnd_in_valid  = (sent < NRAND) && ($urandom_range(0, 3) != 0);
      rnd_a         = 16'($urandom);
      rnd_b         = 16'($urandom);
      rnd_ci        = 1'($urandom);
      rnd_sub       = 1'($urandom);
      rnd_out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (rnd_out_valid && rnd_out_ready) begin
        if (q.size() == 0) begin
          chk("wide_unexpected", {31'd0, rnd_out_valid}, 32'd0);
        end else begin
          exp = q.pop_front();
          chk($sformatf("wide_beat%0d", got), {14'd0, rnd_ov, rnd_co, rnd_sum}, {14'd0, exp});
        end
        got++;
      end
      if (rnd_in_valid && rnd_in_ready) begin
        q.push_back(ref16(rnd_a, rnd_b, rnd_ci, rnd_sub));
        sent++;
      end
      cyc++;
    end
    rnd_in_valid = 1'b0;
    chk("wide_completed", got, NRAND);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
